bin_bcp_ctrl: RTL and testbench



---
 rtl/sat_bin_pkg.sv | 30 +++
 rtl/bin_imp_merge.sv | 67 ++++++
 rtl/bin_bcp_ctrl.sv | 143 ++++++++++++++
 tb/tb_bin_bcp_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_bin_pkg.sv
// sat_bin_pkg: shared definitions for the clause-bin BCP controller.
//   VAR_W          width of one variable field {implied, val[1:0]}
//   VAL_*          two-bit value encodings (11 is reserved and reads as free)
//   result_t       result codes reported to the bin scheduler
//   bcp_state_t    controller FSM states
package sat_bin_pkg;

  localparam int unsigned VAR_W = 3;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;

  typedef enum logic [1:0] {
    RES_UNDET    = 2'b00,
    RES_SAT      = 2'b01,
    RES_CONFLICT = 2'b10,
    RES_TIMEOUT  = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_MERGE,
    ST_CONFL,
    ST_DONE
  } bcp_state_t;

endpackage

// File: rtl/bin_imp_merge.sv
// bin_imp_merge: combinational merge of the implications returned by every
// clause cell against the current bin variable table.
//   cell_val    per-cell implication tables, cell 0 in the MSBs
//   tbl         current variable table
//   new_imp     per-variable mask of implications on free variables
//   merged_val  table with new implications written in (implied bit set)
//   contra      true/false collision, or implication disagreeing with an
//               assigned table value
//   any_new     at least one new implication
module bin_imp_merge
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_LITS    = 8
) (
  input  logic [NUM_CLAUSES*NUM_LITS*VAR_W-1:0] cell_val,
  input  logic [NUM_LITS*VAR_W-1:0]             tbl,
  output logic [NUM_LITS-1:0]                   new_imp,
  output logic [NUM_LITS*VAR_W-1:0]             merged_val,
  output logic                                  contra,
  output logic                                  any_new
);

  localparam int unsigned TW = NUM_LITS * VAR_W;

  logic [NUM_LITS-1:0] imp_t;
  logic [NUM_LITS-1:0] imp_f;
  logic [NUM_LITS-1:0] assigned;
  logic [NUM_LITS-1:0] mism;
  // The implied bit of a cell report carries no information for the merge.
  logic                unused_implied;

  always_comb begin
    imp_t          = '0;
    imp_f          = '0;
    unused_implied = 1'b0;
    for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
      for (int unsigned v = 0; v < NUM_LITS; v++) begin
        // Reserved (11) matches neither value, so it is ignored as free.
        if (cell_val[(NUM_CLAUSES-1-c)*TW + v*VAR_W +: 2] == VAL_TRUE)
          imp_t[v] = 1'b1;
        if (cell_val[(NUM_CLAUSES-1-c)*TW + v*VAR_W +: 2] == VAL_FALSE)
          imp_f[v] = 1'b1;
        unused_implied = unused_implied ^ cell_val[(NUM_CLAUSES-1-c)*TW + v*VAR_W + 2];
      end
    end
  end

  always_comb begin
    assigned   = '0;
    new_imp    = '0;
    mism       = '0;
    merged_val = tbl;
    for (int unsigned v = 0; v < NUM_LITS; v++) begin
      assigned[v] = (tbl[v*VAR_W +: 2] == VAL_TRUE) || (tbl[v*VAR_W +: 2] == VAL_FALSE);
      new_imp[v]  = !assigned[v] && (imp_t[v] || imp_f[v]);
      mism[v]     = (imp_t[v] && imp_f[v]) ||
                    (assigned[v] && imp_t[v] && (tbl[v*VAR_W +: 2] != VAL_TRUE)) ||
                    (assigned[v] && imp_f[v] && (tbl[v*VAR_W +: 2] != VAL_FALSE));
      if (new_imp[v])
        merged_val[v*VAR_W +: VAR_W] = {1'b1, (imp_t[v] ? VAL_TRUE : VAL_FALSE)};
    end
    contra  = |mism;
    any_new = |new_imp;
  end

endmodule

// File: rtl/bin_bcp_ctrl.sv
// bin_bcp_ctrl: sequences Boolean constraint propagation over one clause bin.
// Broadcasts the variable table to the cells (wr_o), strobes implication
// evaluation (imp_drv_o), merges the returned implications and iterates until
// a fixpoint, a conflict or the round limit, then pulses done_o with result_o.
//   clk, rst           clock, synchronous active-high reset
//   start_i, vars_i    begin a run with the given initial table (IDLE only)
//   busy_o             high in every state except IDLE
//   done_o             one-cycle completion pulse
//   result_o, vars_o   result code and final table, held until next done_o
//   wr_o, var_value_o  table broadcast strobe and table to the cells
//   imp_drv_o          implication evaluate strobe
//   var_value_i        per-cell implications, cell 0 in the MSBs
//   clausesat_i        per-cell satisfied flags
//   cclause_i          per-cell conflict flags
//   cclause_drv_o      conflict-clause drive strobe
module bin_bcp_ctrl
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_LITS    = 8,
  parameter int unsigned MAX_ITER    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [NUM_LITS*3-1:0]                 vars_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [1:0]                            result_o,
  output logic [NUM_LITS*3-1:0]                 vars_o,
  output logic                                  wr_o,
  output logic [NUM_LITS*3-1:0]                 var_value_o,
  output logic                                  imp_drv_o,
  input  logic [NUM_CLAUSES*NUM_LITS*3-1:0]     var_value_i,
  input  logic [NUM_CLAUSES-1:0]                clausesat_i,
  input  logic [NUM_CLAUSES-1:0]                cclause_i,
  output logic                                  cclause_drv_o
);

  localparam int unsigned TW = NUM_LITS * VAR_W;
  localparam int unsigned IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  bcp_state_t      state;
  bcp_state_t      state_nxt;
  logic [TW-1:0]   tbl;
  logic [IW-1:0]   iter;
  result_t         result_q;
  result_t         merge_res;
  logic [TW-1:0]   vars_q;

  // Per-variable mask is not needed by the sequencer; any_new summarises it.
  logic [NUM_LITS-1:0] new_imp_unused;
  logic [TW-1:0]       merged_val;
  logic                contra;
  logic                any_new;
  logic                last_round;

  bin_imp_merge #(
    .NUM_CLAUSES (NUM_CLAUSES),
    .NUM_LITS    (NUM_LITS)
  ) u_merge (
    .cell_val   (var_value_i),
    .tbl        (tbl),
    .new_imp    (new_imp_unused),
    .merged_val (merged_val),
    .contra     (contra),
    .any_new    (any_new)
  );

  assign last_round = (iter == IW'(MAX_ITER - 1));

  always_comb begin
    state_nxt = state;
    merge_res = RES_UNDET;
    case (state)
      ST_IDLE:  if (start_i) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_EVAL;
      ST_EVAL:  state_nxt = ST_MERGE;
      ST_MERGE: begin
        if ((|cclause_i) || contra) begin
          state_nxt = ST_CONFL;
        end else if (!any_new) begin
          state_nxt = ST_DONE;
          merge_res = (&clausesat_i) ? RES_SAT : RES_UNDET;
        end else if (last_round) begin
          state_nxt = ST_DONE;
          merge_res = RES_TIMEOUT;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_CONFL: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tbl      <= '0;
      iter     <= '0;
      result_q <= RES_UNDET;
      vars_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            tbl  <= vars_i;
            iter <= '0;
          end
        end
        ST_MERGE: begin
          if (state_nxt == ST_LOAD) begin
            tbl  <= merged_val;
            iter <= iter + 1'b1;
          end
          // Timeout leaves the table as it was before this round.
          if (state_nxt == ST_DONE) begin
            result_q <= merge_res;
            vars_q   <= tbl;
          end
        end
        ST_CONFL: begin
          result_q <= RES_CONFLICT;
          vars_q   <= tbl;
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state != ST_IDLE);
  assign done_o        = (state == ST_DONE);
  assign wr_o          = (state == ST_LOAD);
  assign imp_drv_o     = (state == ST_EVAL);
  assign cclause_drv_o = (state == ST_CONFL);
  assign var_value_o   = tbl;
  assign result_o      = result_q;
  assign vars_o        = vars_q;

endmodule

// File: tb/tb_bin_bcp_ctrl.sv
// Directed bench for bin_bcp_ctrl with a round-level model of propagation.
module tb_bin_bcp_ctrl;

  localparam int NC = 8;
  localparam int NL = 8;
  localparam int TW = NL * 3;
  localparam int CW = NC * NL * 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic [TW-1:0] vars_i = '0;
  logic [CW-1:0] var_value_i = '0;
  logic [NC-1:0] clausesat_i = '0;
  logic [NC-1:0] cclause_i = '0;

  logic          busy_a, done_a, wr_a, imp_a, ccd_a;
  logic [1:0]    res_a;
  logic [TW-1:0] vars_a, vv_a;
  logic          busy_b, done_b, wr_b, imp_b, ccd_b;
  logic [1:0]    res_b;
  logic [TW-1:0] vars_b, vv_b;

  always #5 clk = ~clk;

  bin_bcp_ctrl #(.NUM_CLAUSES(NC), .NUM_LITS(NL), .MAX_ITER(16)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .vars_i(vars_i),
    .busy_o(busy_a), .done_o(done_a), .result_o(res_a), .vars_o(vars_a),
    .wr_o(wr_a), .var_value_o(vv_a), .imp_drv_o(imp_a),
    .var_value_i(var_value_i), .clausesat_i(clausesat_i), .cclause_i(cclause_i),
    .cclause_drv_o(ccd_a)
  );

  bin_bcp_ctrl #(.NUM_CLAUSES(NC), .NUM_LITS(NL), .MAX_ITER(2)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .vars_i(vars_i),
    .busy_o(busy_b), .done_o(done_b), .result_o(res_b), .vars_o(vars_b),
    .wr_o(wr_b), .var_value_o(vv_b), .imp_drv_o(imp_b),
    .var_value_i(var_value_i), .clausesat_i(clausesat_i), .cclause_i(cclause_i),
    .cclause_drv_o(ccd_b)
  );

  // Observed DUT selected by the running case.
  logic          sel = 1'b0;
  logic          o_busy, o_done, o_wr, o_imp, o_ccd;
  logic [1:0]    o_res;
  logic [TW-1:0] o_vars, o_vv;
  always_comb begin
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_wr   = sel ? wr_b   : wr_a;
    o_imp  = sel ? imp_b  : imp_a;
    o_ccd  = sel ? ccd_b  : ccd_a;
    o_res  = sel ? res_b  : res_a;
    o_vars = sel ? vars_b : vars_a;
    o_vv   = sel ? vv_b   : vv_a;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cell stimulus per round; the last entry repeats for later rounds.
  logic [CW-1:0] st_imp [4];
  logic [NC-1:0] st_sat [4];
  logic [NC-1:0] st_cc  [4];
  int            st_n;
  logic [TW-1:0] init_v;

  // Model outputs: cycle offsets from the accepted start cycle.
  int            exp_done, exp_cc, exp_last;
  logic [1:0]    exp_res;
  logic [TW-1:0] exp_vars;
  logic [TW-1:0] exp_tbl [16];

  int cyc = 0;
  bit active = 1'b0;

  function automatic logic [CW-1:0] cset(input logic [CW-1:0] v, input int c,
                                         input int vr, input logic [2:0] f);
    v[((NC-1-c)*NL+vr)*3 +: 3] = f;
    return v;
  endfunction

  task automatic clear_stim();
    for (int r = 0; r < 4; r++) begin
      st_imp[r] = '0;
      st_sat[r] = '0;
      st_cc[r]  = '0;
    end
    st_n   = 1;
    init_v = '0;
  endtask

  // Round-by-round propagation: collect true/false claims per variable,
  // decide conflict / fixpoint / timeout, otherwise assign the free ones.
  task automatic model(input int maxit);
    logic [TW-1:0] tv;
    int            r, s, nnew;
    bit            fin, bad;
    bit            ht[NL];
    bit            hf[NL];
    logic [1:0]    f, cur;
    tv = init_v; r = 0; fin = 0;
    exp_cc = -1; exp_done = 0; exp_res = 2'b00;
    while (!fin) begin
      s = (r < st_n) ? r : st_n - 1;
      exp_tbl[r] = tv;
      bad  = (st_cc[s] != 0);
      nnew = 0;
      for (int v = 0; v < NL; v++) begin
        ht[v] = 0; hf[v] = 0;
        for (int c = 0; c < NC; c++) begin
          f = st_imp[s][((NC-1-c)*NL+v)*3 +: 2];
          if (f == 2'b10) ht[v] = 1;
          if (f == 2'b01) hf[v] = 1;
        end
      end
      for (int v = 0; v < NL; v++) begin
        cur = tv[3*v +: 2];
        if (ht[v] && hf[v]) bad = 1;
        if (cur == 2'b10 && hf[v]) bad = 1;
        if (cur == 2'b01 && ht[v]) bad = 1;
        if ((cur == 2'b00 || cur == 2'b11) && (ht[v] || hf[v])) nnew++;
      end
      if (bad) begin
        exp_res = 2'b10; exp_cc = 4 + 3*r; exp_done = 5 + 3*r; fin = 1;
      end else if (nnew == 0) begin
        exp_res = (st_sat[s] == 8'hFF) ? 2'b01 : 2'b00; exp_done = 4 + 3*r; fin = 1;
      end else if (r == maxit - 1) begin
        exp_res = 2'b11; exp_done = 4 + 3*r; fin = 1;
      end else begin
        for (int v = 0; v < NL; v++) begin
          cur = tv[3*v +: 2];
          if ((cur == 2'b00 || cur == 2'b11) && (ht[v] || hf[v]))
            tv[3*v +: 3] = ht[v] ? 3'b110 : 3'b101;
        end
        r++;
      end
    end
    exp_last = r;
    exp_vars = tv;
  endtask

  task automatic run_case(input bit use_b, input int maxit);
    int rnd, s;
    model(maxit);
    sel = use_b;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    vars_i = init_v; rnd = 0; cyc = 0; active = 1'b1;
    for (int n = 1; n <= exp_done + 2; n++) begin
      @(posedge clk); #1;
      cyc = n;
      start_a = 1'b0; start_b = 1'b0;
      // start in the DONE cycle must be ignored
      if (n == exp_done) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (o_wr) begin
        s = (rnd < st_n) ? rnd : st_n - 1;
        var_value_i = st_imp[s];
        clausesat_i = st_sat[s];
        cclause_i   = st_cc[s];
        rnd++;
      end
    end
    @(posedge clk); #1;
    active = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    var_value_i = '0; clausesat_i = '0; cclause_i = '0;
  endtask

  bit ld, ev;
  always @(negedge clk) begin
    if (active) begin
      ld = (cyc >= 1) && (cyc <= 1 + 3*exp_last) && ((cyc - 1) % 3 == 0);
      ev = (cyc >= 2) && (cyc <= 2 + 3*exp_last) && ((cyc - 2) % 3 == 0);
      chk("busy_o", {31'b0, o_busy}, {31'b0, (cyc >= 1 && cyc <= exp_done)});
      chk("done_o", {31'b0, o_done}, {31'b0, (cyc == exp_done)});
      chk("wr_o", {31'b0, o_wr}, {31'b0, ld});
      chk("imp_drv_o", {31'b0, o_imp}, {31'b0, ev});
      chk("cclause_drv_o", {31'b0, o_ccd}, {31'b0, (cyc == exp_cc)});
      if (ld) chk("var_value_o", {8'b0, o_vv}, {8'b0, exp_tbl[(cyc-1)/3]});
      if (cyc >= exp_done) begin
        chk("result_o", {30'b0, o_res}, {30'b0, exp_res});
        chk("vars_o", {8'b0, o_vars}, {8'b0, exp_vars});
      end
    end
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_vv", {8'b0, vv_a}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {31'b0, busy_a}, 0);
    chk("idle_result", {30'b0, res_a}, 0);

    // Reset during EVAL aborts the run
    clear_stim();
    sel = 1'b0;
    start_a = 1'b1; vars_i = 24'h249249;
    @(posedge clk); #1; start_a = 1'b0;
    @(posedge clk); #1;
    chk("mid_imp_drv", {31'b0, imp_a}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_busy", {31'b0, busy_a}, 0);
    chk("mid_wr", {31'b0, wr_a}, 0);
    chk("mid_imp", {31'b0, imp_a}, 0);
    chk("mid_ccd", {31'b0, ccd_a}, 0);
    chk("mid_done", {31'b0, done_a}, 0);
    chk("mid_result", {30'b0, res_a}, 0);
    chk("mid_vars", {8'b0, vars_a}, 0);
    chk("mid_vv", {8'b0, vv_a}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_no_done", {31'b0, done_a}, 0);
    end

    // All free, no implications, not all satisfied -> UNDET at t+4
    clear_stim();
    run_case(1'b0, 16);
    chk("pin_free_done", exp_done, 4);
    chk("pin_free_res", {30'b0, exp_res}, 0);

    // var7 true; round 1 cell 2 implies var3 false; round 2 quiet, all sat
    clear_stim();
    init_v[21 +: 3] = 3'b010;
    st_imp[0] = cset('0, 2, 3, 3'b001);
    st_sat[1] = 8'hFF;
    st_n = 2;
    run_case(1'b0, 16);
    chk("pin_sat_done", exp_done, 7);
    chk("pin_sat_res", {30'b0, exp_res}, 1);
    chk("pin_sat_var3", {29'b0, exp_vars[9 +: 3]}, 3'b101);

    // cell 0 var5 true vs cell 4 var5 false
    clear_stim();
    st_imp[0] = cset(cset('0, 0, 5, 3'b010), 4, 5, 3'b001);
    run_case(1'b0, 16);
    chk("pin_tf_cc", exp_cc, 4);
    chk("pin_tf_done", exp_done, 5);

    // cclause flag wins over a simultaneous new implication
    clear_stim();
    st_cc[0]  = 8'h10;
    st_imp[0] = cset('0, 1, 0, 3'b010);
    run_case(1'b0, 16);
    chk("pin_cc_res", {30'b0, exp_res}, 2);

    // MAX_ITER=2, a new implication every round -> TIMEOUT
    clear_stim();
    st_imp[0] = cset('0, 3, 0, 3'b010);
    st_imp[1] = cset('0, 6, 1, 3'b001);
    st_n = 2;
    run_case(1'b1, 2);
    chk("pin_to_done", exp_done, 7);
    chk("pin_to_res", {30'b0, exp_res}, 3);
    chk("pin_to_vars", {8'b0, exp_vars}, 32'h000006);

    // Agreeing implication ignored, reserved reads free -> UNDET
    clear_stim();
    init_v = 24'h000080;
    st_imp[0] = cset(cset(cset('0, 1, 2, 3'b010), 3, 6, 3'b011), 5, 4, 3'b010);
    st_sat[1] = 8'h0F;
    st_n = 2;
    run_case(1'b0, 16);
    chk("pin_agree_vars", {8'b0, exp_vars}, 32'h006080);
    chk("pin_agree_done", exp_done, 7);

    // Implication disagreeing with an assigned variable -> CONFLICT
    clear_stim();
    init_v = 24'h000008;
    st_imp[0] = cset('0, 6, 1, 3'b010);
    run_case(1'b0, 16);
    chk("pin_dis_done", exp_done, 5);
    chk("pin_dis_res", {30'b0, exp_res}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
